// File: rtl/inst_fetch.sv
// IF stage: PC register, instruction memory drive and IF/ID pipeline register.
// Handles stall, delay-slot branch redirect, exception redirect and fetch faults.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_i,
  output logic        inst_ce_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_data_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic        if_id_fault_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        fault;
  } if_id_t;

  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        ce;
  logic        fault;
  if_id_t      if_id;
  if_id_t      if_id_nxt;
  if_id_t      fetched;

  assign fault = (pc[1:0] != 2'b00)
               | ({1'b0, pc} >= PC_LIMIT);

  always_comb begin
    fetched.pc    = pc;
    fetched.inst  = fault ? 32'h0 : inst_data_i;
    fetched.valid = 1'b1;
    fetched.fault = fault;
  end

  // exc beats stall; stall beats branch (ID re-asserts it)
  always_comb begin
    pc_nxt    = pc;
    if_id_nxt = if_id;
    priority case (1'b1)
      exc_i: begin
        pc_nxt    = EXC_VECTOR;
        if_id_nxt = '0;
      end
      stall_i: begin
        pc_nxt    = pc;
        if_id_nxt = if_id;
      end
      br_taken_i: begin
        pc_nxt    = br_target_i;
        if_id_nxt = fetched;
      end
      default: begin
        pc_nxt    = pc + 32'd4;
        if_id_nxt = fetched;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      ce    <= 1'b0;
      if_id <= '0;
    end else begin
      ce <= 1'b1;
      if (ce) begin
        pc    <= pc_nxt;
        if_id <= if_id_nxt;
      end
    end
  end

  assign inst_ce_o     = ce;
  assign inst_addr_o   = pc;
  assign if_id_pc_o    = if_id.pc;
  assign if_id_inst_o  = if_id.inst;
  assign if_id_valid_o = if_id.valid;
  assign if_id_fault_o = if_id.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural
// combinational instruction memory.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        exc_i;
  logic        inst_ce_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;
  logic        if_id_fault_o;

  logic [31:0] mem [0:1023];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (inst_addr_o[1:0] == 2'b00 && inst_addr_o < 32'h1000)
      inst_data_i = mem[inst_addr_o[11:2]];
    else
      inst_data_i = 32'hDEAD_BEEF;
  end

  inst_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .exc_i        (exc_i),
    .inst_ce_o    (inst_ce_o),
    .inst_addr_o  (inst_addr_o),
    .inst_data_i  (inst_data_i),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_inst_o (if_id_inst_o),
    .if_id_valid_o(if_id_valid_o),
    .if_id_fault_o(if_id_fault_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [31:0] p,
                          input logic [31:0] i,
                          input logic v,
                          input logic f);
    chk({tag, ".pc"}, if_id_pc_o, p);
    chk({tag, ".inst"}, if_id_inst_o, i);
    chk({tag, ".valid"}, 32'(if_id_valid_o), 32'(v));
    chk({tag, ".fault"}, 32'(if_id_fault_o), 32'(f));
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[0]    = 32'h0000_f025;
    mem[1]    = 32'h241d_1000;
    mem[2]    = 32'h1111_1111;
    mem[3]    = 32'h2222_2222;
    mem[16]   = 32'h5555_5555;
    mem[72]   = 32'h3333_3333;
    mem[73]   = 32'h4444_4444;
    mem[96]   = 32'h6666_6666;
    mem[1023] = 32'h7777_7777;
    rst_n = 1'b0;
    stall_i = 1'b0;
    br_taken_i = 1'b0;
    br_target_i = 32'h0;
    exc_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ce", 32'(inst_ce_o), 32'h0);
    chk("rst.addr", inst_addr_o, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // start-up
    chk("c0.ce", 32'(inst_ce_o), 32'h0);
    chk("c0.addr", inst_addr_o, 32'h0);
    tick();
    chk("c1.ce", 32'(inst_ce_o), 32'h1);
    chk("c1.addr", inst_addr_o, 32'h0);
    chk("c1.valid", 32'(if_id_valid_o), 32'h0);
    tick();
    chk_ifid("c2", 32'h0, 32'h0000_f025, 1'b1, 1'b0);
    chk("c2.addr", inst_addr_o, 32'h4);
    tick();
    chk_ifid("c3", 32'h4, 32'h241d_1000, 1'b1, 1'b0);
    chk("c3.addr", inst_addr_o, 32'h8);

    // branch with delay slot
    tick();
    chk("br.pre.addr", inst_addr_o, 32'hC);
    br_taken_i = 1'b1;
    br_target_i = 32'h120;
    tick();
    chk_ifid("br.slot", 32'hC, 32'h2222_2222, 1'b1, 1'b0);
    chk("br.addr", inst_addr_o, 32'h120);
    br_taken_i = 1'b0;
    tick();
    chk_ifid("br.tgt", 32'h120, 32'h3333_3333, 1'b1, 1'b0);
    chk("br.tgt.addr", inst_addr_o, 32'h124);

    // stall, branch ignored during stall
    br_taken_i = 1'b1;
    br_target_i = 32'h40;
    tick();
    chk("st.pre.addr", inst_addr_o, 32'h40);
    br_taken_i = 1'b0;
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      br_taken_i = (c == 1);
      br_target_i = 32'h200;
      tick();
      chk("st.addr", inst_addr_o, 32'h40);
      chk_ifid("st", 32'h124, 32'h4444_4444, 1'b1, 1'b0);
    end
    stall_i = 1'b0;
    br_taken_i = 1'b0;
    tick();
    chk_ifid("st.rel", 32'h40, 32'h5555_5555, 1'b1, 1'b0);
    chk("st.rel.addr", inst_addr_o, 32'h44);

    // exception overrides stall
    repeat (3) tick();
    chk("exc.pre.addr", inst_addr_o, 32'h50);
    exc_i = 1'b1;
    stall_i = 1'b1;
    tick();
    chk("exc.addr", inst_addr_o, 32'h180);
    chk_ifid("exc", 32'h0, 32'h0, 1'b0, 1'b0);
    exc_i = 1'b0;
    stall_i = 1'b0;
    tick();
    chk_ifid("exc.vec", 32'h180, 32'h6666_6666, 1'b1, 1'b0);
    chk("exc.vec.addr", inst_addr_o, 32'h184);

    // misaligned target
    br_taken_i = 1'b1;
    br_target_i = 32'h102;
    tick();
    chk("mis.addr", inst_addr_o, 32'h102);
    chk_ifid("mis.slot", 32'h184, 32'h0, 1'b1, 1'b0);
    br_taken_i = 1'b0;
    tick();
    chk_ifid("mis", 32'h102, 32'h0, 1'b1, 1'b1);
    chk("mis.next", inst_addr_o, 32'h106);

    // last word, then out of range
    br_taken_i = 1'b1;
    br_target_i = 32'hFFC;
    tick();
    chk("last.addr", inst_addr_o, 32'hFFC);
    chk_ifid("mis2", 32'h106, 32'h0, 1'b1, 1'b1);
    br_taken_i = 1'b0;
    tick();
    chk_ifid("last", 32'hFFC, 32'h7777_7777, 1'b1, 1'b0);
    chk("oor.addr", inst_addr_o, 32'h1000);
    tick();
    chk_ifid("oor", 32'h1000, 32'h0, 1'b1, 1'b1);

    // 32-bit wrap
    br_taken_i = 1'b1;
    br_target_i = 32'hFFFF_FFFC;
    tick();
    chk("wrap.pre", inst_addr_o, 32'hFFFF_FFFC);
    br_taken_i = 1'b0;
    tick();
    chk("wrap.addr", inst_addr_o, 32'h0);
    chk_ifid("wrap.top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1);
    tick();
    chk_ifid("wrap.zero", 32'h0, 32'h0000_f025, 1'b1, 1'b0);
    chk("wrap.next", inst_addr_o, 32'h4);

    // async reset mid-run
    br_taken_i = 1'b1;
    br_target_i = 32'h88;
    tick();
    br_taken_i = 1'b0;
    chk("ar.pre", inst_addr_o, 32'h88);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.ce", 32'(inst_ce_o), 32'h0);
    chk("ar.addr", inst_addr_o, 32'h0);
    chk_ifid("ar", 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("ar.c1.ce", 32'(inst_ce_o), 32'h1);
    chk("ar.c1.addr", inst_addr_o, 32'h0);
    tick();
    chk_ifid("ar.c2", 32'h0, 32'h0000_f025, 1'b1, 1'b0);
    chk("ar.c2.addr", inst_addr_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
